// File: rtl/snn_seq_network.sv
// snn_seq_network: time-multiplexed leaky integrate-and-fire network.
// One shared neuron datapath walks every layer in layer-major order per step.
module snn_seq_network #(
  parameter int NUM_LAYERS = 3,
  parameter int NEURONS    = 3,
  parameter int WEIGHT_W   = 8,
  parameter int POT_W      = 8,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     step_valid,
  output logic                                     step_ready,
  input  logic [NEURONS-1:0]                       external_input_spikes,
  input  logic [NUM_LAYERS*NEURONS*NEURONS*WEIGHT_W-1:0] input_weights,
  input  logic [NUM_LAYERS*4*POT_W-1:0]            neuron_params,
  output logic [NEURONS-1:0]                       output_spikes,
  output logic                                     spike_valid,
  input  logic [LW-1:0]                            dbg_layer,
  input  logic [NW-1:0]                            dbg_neuron,
  output logic [POT_W-1:0]                         dbg_potential
);

  localparam int CW = (NEURONS > 1) ? $clog2(NEURONS) : 0;
  localparam int SW = (WEIGHT_W + CW > POT_W) ? (WEIGHT_W + CW) : POT_W;
  localparam int AW = SW + 2;
  localparam int RW = NEURONS * WEIGHT_W;
  localparam int LS = NEURONS * RW;
  localparam int PS = 4 * POT_W;

  typedef enum logic {
    S_IDLE,
    S_EVAL
  } state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_spike_valid;
  logic [NEURONS-1:0]   r_out;
  logic [NEURONS-1:0]   r_x;
  logic [LW-1:0]        r_l;
  logic [NW-1:0]        r_n;
  logic [POT_W-1:0]     r_v [NUM_LAYERS][NEURONS];
  logic [POT_W-1:0]     r_r [NUM_LAYERS][NEURONS];
  logic [NEURONS-1:0]   r_s [NUM_LAYERS];

  logic [NEURONS-1:0]   w_in;
  logic [NEURONS-1:0]   w_last_s;
  logic [RW-1:0]        w_row;
  logic [PS-1:0]        w_prm;
  logic [POT_W-1:0]     w_v;
  logic [POT_W-1:0]     w_r;
  logic [POT_W-1:0]     w_thr;
  logic [POT_W-1:0]     w_leak;
  logic [POT_W-1:0]     w_rpot;
  logic [POT_W-1:0]     w_refr;
  logic [POT_W-1:0]     w_bc;
  logic [POT_W-1:0]     w_v_nx;
  logic [POT_W-1:0]     w_r_nx;
  logic [WEIGHT_W-1:0]  w_wt;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_a;
  logic signed [AW-1:0] w_ac;
  logic signed [AW-1:0] w_b;
  logic                 w_s_nx;
  logic                 w_last;

  assign step_ready    = r_ready;
  assign spike_valid   = r_spike_valid;
  assign output_spikes = r_out;

  // Layer l>0 reads spikes its predecessor produced earlier in this same step.
  always_comb begin
    w_in  = r_x;
    w_row = '0;
    w_prm = '0;
    w_v   = '0;
    w_r   = '0;
    for (int l = 1; l < NUM_LAYERS; l++) begin
      if (r_l == LW'(l)) w_in = r_s[l-1];
    end
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (r_l == LW'(l)) begin
        w_prm = neuron_params[(NUM_LAYERS-1-l)*PS +: PS];
        for (int n = 0; n < NEURONS; n++) begin
          if (r_n == NW'(n)) begin
            w_row = input_weights[(NUM_LAYERS-1-l)*LS + n*RW +: RW];
            w_v   = r_v[l][n];
            w_r   = r_r[l][n];
          end
        end
      end
    end
  end

  assign w_thr  = w_prm[0*POT_W +: POT_W];
  assign w_leak = w_prm[1*POT_W +: POT_W];
  assign w_rpot = w_prm[2*POT_W +: POT_W];
  assign w_refr = w_prm[3*POT_W +: POT_W];

  always_comb begin
    w_sum = '0;
    w_wt  = '0;
    for (int i = 0; i < NEURONS; i++) begin
      w_wt = w_row[i*WEIGHT_W +: WEIGHT_W];
      if (w_in[i]) begin
        w_sum = w_sum + {{(AW-WEIGHT_W){w_wt[WEIGHT_W-1]}}, w_wt};
      end
    end
  end

  assign w_a  = $signed({{(AW-POT_W){1'b0}}, w_v})
              - $signed({{(AW-POT_W){1'b0}}, w_leak});
  assign w_ac = w_a[AW-1] ? '0 : w_a;
  assign w_b  = w_ac + w_sum;
  // Saturate the signed sum into the unsigned potential range.
  assign w_bc = w_b[AW-1]            ? '0 :
                (|w_b[AW-2:POT_W])   ? '1 :
                w_b[POT_W-1:0];

  always_comb begin
    w_s_nx = 1'b0;
    w_v_nx = w_v;
    w_r_nx = w_r;
    if (w_r != '0) begin
      w_r_nx = w_r - POT_W'(1);
    end else if (w_bc >= w_thr) begin
      w_s_nx = 1'b1;
      w_v_nx = w_rpot;
      w_r_nx = w_refr;
    end else begin
      w_v_nx = w_bc;
    end
  end

  assign w_last = (r_l == LW'(NUM_LAYERS-1))
               && (r_n == NW'(NEURONS-1));

  always_comb begin
    w_last_s = r_s[NUM_LAYERS-1];
    for (int n = 0; n < NEURONS; n++) begin
      if (r_n == NW'(n)) w_last_s[n] = w_s_nx;
    end
  end

  always_comb begin
    dbg_potential = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      for (int n = 0; n < NEURONS; n++) begin
        if (dbg_layer == LW'(l) && dbg_neuron == NW'(n)) begin
          dbg_potential = r_v[l][n];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_spike_valid <= 1'b0;
      r_out         <= '0;
      r_x           <= '0;
      r_l           <= '0;
      r_n           <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        r_s[l] <= '0;
        for (int n = 0; n < NEURONS; n++) begin
          r_v[l][n] <= '0;
          r_r[l][n] <= '0;
        end
      end
    end else begin
      r_spike_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (step_valid) begin
            r_state <= S_EVAL;
            r_ready <= 1'b0;
            r_x     <= external_input_spikes;
            r_l     <= '0;
            r_n     <= '0;
          end
        end
        S_EVAL: begin
          for (int l = 0; l < NUM_LAYERS; l++) begin
            for (int n = 0; n < NEURONS; n++) begin
              if (r_l == LW'(l) && r_n == NW'(n)) begin
                r_v[l][n] <= w_v_nx;
                r_r[l][n] <= w_r_nx;
                r_s[l][n] <= w_s_nx;
              end
            end
          end
          if (w_last) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_out         <= w_last_s;
            r_spike_valid <= 1'b1;
          end else if (r_n == NW'(NEURONS-1)) begin
            r_n <= '0;
            r_l <= r_l + LW'(1);
          end else begin
            r_n <= r_n + NW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_seq_network.sv
// Bench for snn_seq_network: directed vector table, handshake/abort
// sequences, and randomized steps against an arithmetic network model.
`timescale 1ns/1ps
module tb_snn_seq_network;
  localparam int L  = 3;
  localparam int N  = 3;
  localparam int WW = 8;
  localparam int PW = 8;
  localparam int K  = L * N;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 step_valid;
  logic                 step_ready;
  logic [N-1:0]         ext;
  logic [L*N*N*WW-1:0]  input_weights;
  logic [L*4*PW-1:0]    neuron_params;
  logic [N-1:0]         output_spikes;
  logic                 spike_valid;
  logic [1:0]           dbg_layer;
  logic [1:0]           dbg_neuron;
  logic [PW-1:0]        dbg_potential;

  int errors = 0;
  int checks = 0;

  int mw [L][N][N];
  int thr [L];
  int lk [L];
  int rp [L];
  int rf [L];
  int mv [L][N];
  int mr [L][N];

  typedef struct {
    int           cfg;
    logic [N-1:0] x;
    logic [N-1:0] out;
    int           v00;
    int           v01;
    int           v10;
  } vec_t;

  vec_t tbl [13];

  always #20 clk = ~clk;

  snn_seq_network dut (
    .clk                   (clk),
    .reset                 (reset),
    .step_valid            (step_valid),
    .step_ready            (step_ready),
    .external_input_spikes (ext),
    .input_weights         (input_weights),
    .neuron_params         (neuron_params),
    .output_spikes         (output_spikes),
    .spike_valid           (spike_valid),
    .dbg_layer             (dbg_layer),
    .dbg_neuron            (dbg_neuron),
    .dbg_potential         (dbg_potential)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pot(input string nm, input int l, input int n,
                         input int exp);
    dbg_layer  = 2'(l);
    dbg_neuron = 2'(n);
    #1;
    chk($sformatf("%s_V%0d%0d", nm, l, n), int'(dbg_potential), exp);
  endtask

  task automatic model_clear();
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++) begin
        mv[l][n] = 0;
        mr[l][n] = 0;
      end
  endtask

  // Evaluate the whole network for one time step from the rules.
  function automatic logic [N-1:0] model_step(input logic [N-1:0] x);
    logic [N-1:0] inp;
    logic [N-1:0] nxt;
    int a;
    int b;
    inp = x;
    for (int l = 0; l < L; l++) begin
      nxt = '0;
      for (int n = 0; n < N; n++) begin
        if (mr[l][n] > 0) begin
          mr[l][n] = mr[l][n] - 1;
        end else begin
          a = mv[l][n] - lk[l];
          if (a < 0) a = 0;
          b = a;
          for (int i = 0; i < N; i++)
            if (inp[i]) b = b + mw[l][n][i];
          if (b < 0) b = 0;
          if (b > 255) b = 255;
          if (b >= thr[l]) begin
            nxt[n]   = 1'b1;
            mv[l][n] = rp[l];
            mr[l][n] = rf[l];
          end else begin
            mv[l][n] = b;
          end
        end
      end
      inp = nxt;
    end
    return inp;
  endfunction

  task automatic pack();
    for (int l = 0; l < L; l++) begin
      for (int n = 0; n < N; n++)
        for (int i = 0; i < N; i++)
          input_weights[((L-1-l)*N*N + n*N + i)*WW +: WW] = WW'(mw[l][n][i]);
      neuron_params[(L-1-l)*4*PW +: 4*PW] =
        {PW'(rf[l]), PW'(rp[l]), PW'(lk[l]), PW'(thr[l])};
    end
  endtask

  task automatic set_uniform(input int w, input int t, input int k,
                             input int r, input int f);
    for (int l = 0; l < L; l++) begin
      for (int n = 0; n < N; n++)
        for (int i = 0; i < N; i++)
          mw[l][n][i] = w;
      thr[l] = t;
      lk[l]  = k;
      rp[l]  = r;
      rf[l]  = f;
    end
  endtask

  task automatic set_cfg(input int c);
    if (c == 1) begin
      set_uniform(100, 150, 0, 0, 0);
    end else if (c == 2) begin
      set_uniform(-128, 150, 0, 0, 0);
    end else if (c == 3) begin
      set_uniform(1, 1, 0, 0, 2);
    end else begin
      set_uniform(0, 255, 20, 0, 0);
      mw[0][0][0] = 50;
    end
    pack();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    step_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Issue one step from a negedge; return at the negedge where spike_valid is seen.
  task automatic run_step(input string tag, input logic [N-1:0] x,
                          input logic [N-1:0] exp);
    int cyc;
    chk({tag, "_ready"}, int'(step_ready), 1);
    ext        = x;
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    ext        = ~x;
    cyc        = 0;
    while (spike_valid !== 1'b1 && cyc < 4*K) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy"}, int'(step_ready), 0);
    end
    chk({tag, "_latency"}, cyc, K);
    chk({tag, "_out"}, int'(output_spikes), int'(exp));
    chk({tag, "_ready_done"}, int'(step_ready), 1);
  endtask

  task automatic random_cfg();
    for (int l = 0; l < L; l++) begin
      for (int n = 0; n < N; n++)
        for (int i = 0; i < N; i++)
          mw[l][n][i] = int'($urandom_range(255, 0)) - 128;
      thr[l] = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(255, 0));
      lk[l]  = int'($urandom_range(40, 0));
      rp[l]  = int'($urandom_range(100, 0));
      rf[l]  = int'($urandom_range(3, 0));
    end
    pack();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cur;
    int pulses;
    int last;
    int gaps_bad;
    logic [N-1:0] x;
    logic [N-1:0] e;

    reset         = 1'b1;
    step_valid    = 1'b0;
    ext           = '0;
    dbg_layer     = '0;
    dbg_neuron    = '0;
    input_weights = '0;
    neuron_params = '0;
    model_clear();

    tbl[0]  = '{1, 3'b001, 3'b000, 100, 100, 0};
    tbl[1]  = '{1, 3'b001, 3'b111, 0, 0, 0};
    tbl[2]  = '{2, 3'b111, 3'b000, 0, 0, 0};
    tbl[3]  = '{2, 3'b111, 3'b000, 0, 0, 0};
    tbl[4]  = '{2, 3'b111, 3'b000, 0, 0, 0};
    tbl[5]  = '{3, 3'b111, 3'b111, -1, -1, -1};
    tbl[6]  = '{3, 3'b111, 3'b000, -1, -1, -1};
    tbl[7]  = '{3, 3'b111, 3'b000, -1, -1, -1};
    tbl[8]  = '{3, 3'b111, 3'b111, -1, -1, -1};
    tbl[9]  = '{3, 3'b111, 3'b000, -1, -1, -1};
    tbl[10] = '{4, 3'b001, 3'b000, 50, 0, 0};
    tbl[11] = '{4, 3'b001, 3'b000, 80, 0, 0};
    tbl[12] = '{4, 3'b001, 3'b000, 110, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", int'(step_ready), 1);
    chk("rst_out", int'(output_spikes), 0);
    chk("rst_sv", int'(spike_valid), 0);
    chk_pot("rst", 0, 0, 0);
    chk_pot("rst", 2, 2, 0);

    // Directed vector table
    cur = -1;
    for (int k = 0; k < 13; k++) begin
      if (tbl[k].cfg != cur) begin
        cur = tbl[k].cfg;
        do_reset();
        set_cfg(cur);
      end
      void'(model_step(tbl[k].x));
      run_step($sformatf("vec%0d", k), tbl[k].x, tbl[k].out);
      if (tbl[k].v00 >= 0) chk_pot($sformatf("vec%0d", k), 0, 0, tbl[k].v00);
      if (tbl[k].v01 >= 0) chk_pot($sformatf("vec%0d", k), 0, 1, tbl[k].v01);
      if (tbl[k].v10 >= 0) chk_pot($sformatf("vec%0d", k), 1, 0, tbl[k].v10);
    end

    // step_valid held high: one acceptance per K+1 cycles
    do_reset();
    set_cfg(1);
    @(negedge clk);
    ext        = 3'b001;
    step_valid = 1'b1;
    pulses     = 0;
    last       = -1;
    gaps_bad   = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (spike_valid) begin
        if (last >= 0 && c - last != K + 1) gaps_bad++;
        last = c;
        pulses++;
        e = model_step(3'b001);
        chk($sformatf("held_out%0d", pulses), int'(output_spikes), int'(e));
      end
    end
    step_valid = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_gaps", gaps_bad, 0);

    // step_valid pulse while busy is dropped
    do_reset();
    set_cfg(1);
    @(negedge clk);
    ext        = 3'b001;
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    repeat (3) @(negedge clk);
    step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    pulses     = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (spike_valid) pulses++;
    end
    chk("busy_pulses", pulses, 1);
    chk("busy_ready", int'(step_ready), 1);

    // Reset in the middle of EVAL aborts the step
    do_reset();
    set_cfg(4);
    void'(model_step(3'b001));
    run_step("abort_pre", 3'b001, 3'b000);
    chk_pot("abort_pre", 0, 0, 50);
    ext        = 3'b001;
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(step_ready), 1);
    chk("abort_out", int'(output_spikes), 0);
    chk("abort_sv", int'(spike_valid), 0);
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        chk_pot("abort", l, n, 0);
    reset = 1'b0;
    model_clear();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (spike_valid) pulses++;
    end
    chk("abort_no_sv", pulses, 0);
    void'(model_step(3'b001));
    run_step("abort_post", 3'b001, 3'b000);
    chk_pot("abort_post", 0, 0, 50);
    chk_pot("dbg_oor_l", 3, 0, 0);
    chk_pot("dbg_oor_n", 0, 3, 0);

    // Randomized steps against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      random_cfg();
      for (int s = 0; s < 15; s++) begin
        x = N'($urandom);
        e = model_step(x);
        run_step($sformatf("rnd%0d_%0d", r, s), x, e);
        for (int l = 0; l < L; l++)
          for (int n = 0; n < N; n++)
            chk_pot($sformatf("rnd%0d_%0d", r, s), l, n, mv[l][n]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_seq_network.md
# snn_seq_network

Parametrised, time-multiplexed leaky integrate-and-fire network with NUM_LAYERS fully connected layers of NEURONS neurons each. It generalises our fixed 3×3 three-layer network. A single shared neuron-update datapath evaluates one neuron per cycle, in layer-major order, once per accepted time step. Per-neuron refractory periods, saturating arithmetic, a valid/ready step handshake and a debug read port are added. It sits between the external spike inputs and the output pins, in place of the fixed three-layer network.

## Interface
- NUM_LAYERS, 3, number of layers (≥1)
- NEURONS, 3, neurons per layer; also the input count of every layer (≥1)
- WEIGHT_W, 8, signed two's-complement weight width
- POT_W, 8, unsigned membrane-potential width; each neuron-parameter field is POT_W bits
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- step_valid  in  1  request one time step; the step is accepted on an edge where step_valid && step_ready
- step_ready  out  1  high in IDLE
- external_input_spikes  in  NEURONS  layer-0 input spikes; sampled on the accepting edge
- input_weights  in  NUM_LAYERS*NEURONS*NEURONS*WEIGHT_W  layer l slice at [(NUM_LAYERS-1-l)*NEURONS*NEURONS*WEIGHT_W +: NEURONS*NEURONS*WEIGHT_W]; within a slice, weight (neuron n, input i) at [(n*NEURONS+i)*WEIGHT_W +: WEIGHT_W]
- neuron_params  in  NUM_LAYERS*4*POT_W  layer l slice at [(NUM_LAYERS-1-l)*4*POT_W +: 4*POT_W]; slice fields from LSB: threshold, leak, reset_potential, refractory
- output_spikes  out  NEURONS  last-layer spikes of the most recent completed step; registered
- spike_valid  out  1  one-cycle pulse; marks a step completion
- dbg_layer  in  clog2(NUM_LAYERS) (min 1)  debug layer select
- dbg_neuron  in  clog2(NEURONS) (min 1)  debug neuron select
- dbg_potential  out  POT_W  combinational read of the selected potential; 0 for out-of-range selects

Weights and parameters are static while step_ready=0. The default layout is bit-compatible with the 216-bit weight bus and 96-bit parameter bus of the fixed three-layer network.

## Operation
- State: potential V[l][n] (POT_W), refractory counter R[l][n] (POT_W), spike register S[l][n], latched inputs X (NEURONS).
- FSM IDLE → EVAL on acceptance: latch X, idx_l=0, idx_n=0.
- EVAL: update one neuron (idx_l, idx_n) per cycle. Increment idx_n; on wrap, increment idx_l. After neuron (NUM_LAYERS-1, NEURONS-1), return to IDLE.
- Neuron inputs: X for layer 0; S[l-1][*] for layer l>0. These are the values just computed in the same step, so the whole network propagates in one step.
- Update rule, computed at width max(POT_W, WEIGHT_W+clog2(NEURONS))+2, signed:
  - If R>0: R←R-1, S←0, V held; no integration.
  - Otherwise, first compute a = max(V - leak, 0).
  - Then compute b = a + Σ w(n,i) over inputs i with spike=1.
  - Clamp b to [0, 2^POT_W-1].
  - If clamped b ≥ threshold: S←1, V←reset_potential, R←refractory.
  - Else: S←0, V←clamped b.
- On the final EVAL edge: output_spikes←S[NUM_LAYERS-1][*] as updated on that edge; spike_valid←1.
- step_valid while step_ready=0 is ignored. It is neither queued nor latched.
- reset at any time, including mid-EVAL, goes to IDLE and clears all V, R, S, X, output_spikes and spike_valid. An interrupted step produces no spike_valid.
- threshold=0: the neuron fires on every non-refractory step. refractory=0: the neuron can fire on consecutive steps.

## Timing
- Reset values: step_ready=1 (IDLE), output_spikes=0, spike_valid=0, dbg_potential=0.
- Accepting edge E0; update edges E1..E_K with K=NUM_LAYERS*NEURONS; step_ready=0 from E0 through E_K.
- After E_K: spike_valid=1 and step_ready=1 in the same cycle. Latency from E0 to that cycle is K cycles.
- A new step can be accepted on E_{K+1} (back-to-back). Throughput is one step per K+1 cycles.
- spike_valid is high for exactly one cycle per completed step. output_spikes holds until the next completion or reset.
- dbg_potential reflects register state with zero-cycle combinational delay.

## Test plan
Configuration for all scenarios: defaults; all layers use the same parameters unless stated.
- Reset: hold reset 2 cycles → step_ready=1, output_spikes=0, spike_valid=0. Any dbg select reads 0.
- Accumulate and fire: weights=+100, threshold=150, leak=0, reset_potential=0, refractory=0, input 3'b001.
  - Step 1 → spike_valid 9 cycles after acceptance, output_spikes=000, dbg V[0][*]=100.
  - Step 2 → output_spikes=111; V[0][*]=0; V[1][*]=0 (300 clamped to 255, which fires).
- Negative saturation: weights=-128 (0x80), input 3'b111, three steps → all potentials read 0, output_spikes=000 each step.
- Refractory: weights=+1, threshold=1, refractory=2, input 3'b111 each step → output_spikes over steps 1..5 = 111, 000, 000, 111, 000.
- Leak: single weight w(0,0)=+50, all other weights 0, leak=20, threshold=255, input 3'b001 each step → V[0][0]=50, 80, 110.
- Handshake and reset abort:
  - step_valid held high → accepts exactly every 10 cycles. Pulses while busy cause no extra steps.
  - reset asserted at EVAL cycle 4 → IDLE next cycle, all V=0, no spike_valid.
